// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared CPU definitions for ID-stage branch resolution: FSM state encoding,
// hazard classes, branch opcodes and the register-match helper.
package branch_resolve_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_e;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_ONE  = 2'd1,
    HZ_TWO  = 2'd2
  } hazard_e;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || (op == OP_REGIMM);
  endfunction

  // Register 0 is hardwired, so a write to it can never feed a branch.
  function automatic logic rd_match(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_hazard_classify.sv
// Classifies the ID-stage branch by how many cycles its operands are still
// in flight: none, one (ALU result in EX or load in MEM), two (load in EX).
module hazard_classify
  import branch_resolve_ctrl_pkg::*;
(
  input  logic       uses_rt,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       reg_write_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_mem,
  input  logic [4:0] rd_mem,
  output hazard_e    hazard
);

  logic match_ex_s;
  logic match_mem_s;
  logic h2_s;
  logic h1_s;

  assign match_ex_s  = rd_match(rd_ex, rs_id, rt_id, uses_rt);
  assign match_mem_s = rd_match(rd_mem, rs_id, rt_id, uses_rt);
  assign h2_s        = mem_read_ex && match_ex_s;
  assign h1_s        = !h2_s && ((reg_write_ex && match_ex_s) || (mem_read_mem && match_mem_s));

  // Priority encode the hazard class; a load in EX dominates.
  always_comb begin
    hazard = HZ_NONE;
    if (h2_s) begin
      hazard = HZ_TWO;
    end else if (h1_s) begin
      hazard = HZ_ONE;
    end else begin
      hazard = HZ_NONE;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution controller: stalls until branch operands are
// available, then steers PC and squashes IF/ID; counts resolved/taken branches.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IsBranch,
  input  logic        UsesRt,
  input  logic        BranchTaken,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        RegWrite_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rd_EX,
  input  logic        RegWrite_MEM,
  input  logic        MemRead_MEM,
  input  logic [4:0]  Rd_MEM,
  output logic        Stall,
  output logic        FlushIDEX,
  output logic        FlushIFID,
  output logic        PCSrc,
  output logic [15:0] BranchCount,
  output logic [15:0] TakenCount
);

  localparam logic FLUSH_ON_TAKEN = (DELAY_SLOT == 0);

  br_state_e state_r;
  br_state_e next_state_s;
  hazard_e   hazard_s;
  logic      resolve_s;
  logic      stall_cycle_s;
  logic      unused_reg_write_mem_s;

  // A MEM-stage ALU result is already forwardable to the comparator.
  assign unused_reg_write_mem_s = RegWrite_MEM;

  hazard_classify u_hazard_classify (
    .uses_rt      (UsesRt),
    .rs_id        (Rs_ID),
    .rt_id        (Rt_ID),
    .reg_write_ex (RegWrite_EX),
    .mem_read_ex  (MemRead_EX),
    .rd_ex        (Rd_EX),
    .mem_read_mem (MemRead_MEM),
    .rd_mem       (Rd_MEM),
    .hazard       (hazard_s)
  );

  // Next-state and cycle-type decode; hazard inputs only matter in IDLE.
  always_comb begin
    next_state_s  = ST_IDLE;
    resolve_s     = 1'b0;
    stall_cycle_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (IsBranch) begin
          case (hazard_s)
            HZ_NONE: begin
              resolve_s    = 1'b1;
              next_state_s = ST_IDLE;
            end
            HZ_ONE: begin
              stall_cycle_s = 1'b1;
              next_state_s  = ST_RESOLVE;
            end
            HZ_TWO: begin
              stall_cycle_s = 1'b1;
              next_state_s  = ST_STALL;
            end
            default: begin
              next_state_s = ST_IDLE;
            end
          endcase
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STALL: begin
        stall_cycle_s = 1'b1;
        next_state_s  = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        resolve_s    = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Pipeline control outputs follow the current cycle type with no latency.
  always_comb begin
    Stall     = stall_cycle_s;
    FlushIDEX = stall_cycle_s;
    PCSrc     = 1'b0;
    FlushIFID = 1'b0;
    if (resolve_s) begin
      PCSrc     = BranchTaken;
      FlushIFID = BranchTaken && FLUSH_ON_TAKEN;
    end else begin
      PCSrc     = 1'b0;
      FlushIFID = 1'b0;
    end
  end

  // State and saturating counters; reset wins over any update that cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      BranchCount <= 16'd0;
      TakenCount  <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (resolve_s && (BranchCount != CNT_MAX)) begin
        BranchCount <= BranchCount + 16'd1;
      end
      if (resolve_s && BranchTaken && (TakenCount != CNT_MAX)) begin
        TakenCount <= TakenCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a reference model pushes expected
// outputs per cycle, which are popped and compared mid-cycle on both variants.
module tb_branch_resolve_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IsBranch, UsesRt, BranchTaken;
  logic [4:0]  Rs_ID, Rt_ID, Rd_EX, Rd_MEM;
  logic        RegWrite_EX, MemRead_EX, RegWrite_MEM, MemRead_MEM;
  logic        stall0, fidex0, fifid0, pcsrc0;
  logic        stall1, fidex1, fifid1, pcsrc1;
  logic [15:0] bc0, tc0, bc1, tc1;

  typedef struct packed {
    logic        stall;
    logic        fidex;
    logic        pcsrc;
    logic        fifid0;
    logic        fifid1;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_state  = 0;
  logic [15:0] m_bc     = 16'd0;
  logic [15:0] m_tc     = 16'd0;

  always #5 Clk = ~Clk;

  branch_resolve_ctrl #(.DELAY_SLOT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .IsBranch(IsBranch), .UsesRt(UsesRt),
    .BranchTaken(BranchTaken), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .Rd_MEM(Rd_MEM),
    .Stall(stall0), .FlushIDEX(fidex0), .FlushIFID(fifid0), .PCSrc(pcsrc0),
    .BranchCount(bc0), .TakenCount(tc0)
  );

  branch_resolve_ctrl #(.DELAY_SLOT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .IsBranch(IsBranch), .UsesRt(UsesRt),
    .BranchTaken(BranchTaken), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX),
    .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .Rd_MEM(Rd_MEM),
    .Stall(stall1), .FlushIDEX(fidex1), .FlushIFID(fifid1), .PCSrc(pcsrc1),
    .BranchCount(bc1), .TakenCount(tc1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_match(input logic [4:0] rd);
    return (rd != 5'd0) && ((rd == Rs_ID) || (UsesRt && (rd == Rt_ID)));
  endfunction

  function automatic int m_hazard();
    if (MemRead_EX && m_match(Rd_EX)) return 2;
    if ((RegWrite_EX && m_match(Rd_EX)) || (MemRead_MEM && m_match(Rd_MEM))) return 1;
    return 0;
  endfunction

  // One clock: predict, push, compare mid-cycle, then advance the model at the edge.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t got;
    bit   res;
    int   nxt;
    int   h;
    e   = '0;
    res = 1'b0;
    nxt = 0;
    h   = m_hazard();
    case (m_state)
      0: begin
        if (IsBranch && h == 0) res = 1'b1;
        else if (IsBranch) begin
          e.stall = 1'b1; e.fidex = 1'b1; nxt = (h == 2) ? 1 : 2;
        end
      end
      1: begin e.stall = 1'b1; e.fidex = 1'b1; nxt = 2; end
      default: begin res = 1'b1; nxt = 0; end
    endcase
    if (res) begin
      e.pcsrc  = BranchTaken;
      e.fifid0 = BranchTaken;
      e.fifid1 = 1'b0;
    end
    e.bc = m_bc;
    e.tc = m_tc;
    sb_q.push_back(e);
    @(negedge Clk);
    got = sb_q.pop_front();
    chk({tag, ".stall"},   {15'd0, stall0}, {15'd0, got.stall});
    chk({tag, ".flidex"},  {15'd0, fidex0}, {15'd0, got.fidex});
    chk({tag, ".pcsrc"},   {15'd0, pcsrc0}, {15'd0, got.pcsrc});
    chk({tag, ".flifid"},  {15'd0, fifid0}, {15'd0, got.fifid0});
    chk({tag, ".ds_stall"},{15'd0, stall1}, {15'd0, got.stall});
    chk({tag, ".ds_pcsrc"},{15'd0, pcsrc1}, {15'd0, got.pcsrc});
    chk({tag, ".ds_flifid"},{15'd0, fifid1},{15'd0, got.fifid1});
    chk({tag, ".bcnt"},    bc0, got.bc);
    chk({tag, ".tcnt"},    tc0, got.tc);
    chk({tag, ".ds_bcnt"}, bc1, got.bc);
    @(posedge Clk);
    if (Reset) begin
      m_state = 0; m_bc = 16'd0; m_tc = 16'd0;
    end else begin
      if (res && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (res && BranchTaken && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
      m_state = nxt;
    end
    #1;
  endtask

  task automatic clear_inputs();
    IsBranch = 1'b0; UsesRt = 1'b0; BranchTaken = 1'b0;
    Rs_ID = 5'd0; Rt_ID = 5'd0; Rd_EX = 5'd0; Rd_MEM = 5'd0;
    RegWrite_EX = 1'b0; MemRead_EX = 1'b0; RegWrite_MEM = 1'b0; MemRead_MEM = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    cycle("reset_idle");
    IsBranch = 1'b1; cycle("reset_idle_nobranch_first");

    // Taken branch with no hazard resolves immediately.
    clear_inputs(); IsBranch = 1'b1; BranchTaken = 1'b1; Rs_ID = 5'd3;
    cycle("h0_taken");
    clear_inputs(); cycle("h0_counts");

    // ALU result in EX: one stall, comparator result sampled at resolve.
    IsBranch = 1'b1; UsesRt = 1'b1; Rs_ID = 5'd5; Rt_ID = 5'd9;
    RegWrite_EX = 1'b1; Rd_EX = 5'd5;
    cycle("h1_ex_stall");
    BranchTaken = 1'b1; cycle("h1_ex_resolve");
    clear_inputs(); cycle("h1_after");

    // Load in EX on Rt: two stalls, inputs in STALL/RESOLVE ignored.
    IsBranch = 1'b1; UsesRt = 1'b1; Rs_ID = 5'd2; Rt_ID = 5'd7;
    MemRead_EX = 1'b1; Rd_EX = 5'd7;
    cycle("h2_stall_a");
    IsBranch = 1'b0; cycle("h2_stall_b");
    IsBranch = 1'b1; BranchTaken = 1'b1; cycle("h2_resolve");
    UsesRt = 1'b0; BranchTaken = 1'b0; cycle("h2_usesrt0_nostall");

    // Load in MEM: one stall.
    clear_inputs(); IsBranch = 1'b1; Rs_ID = 5'd12; MemRead_MEM = 1'b1; Rd_MEM = 5'd12;
    cycle("h1_mem_stall");
    BranchTaken = 1'b1; cycle("h1_mem_resolve");

    // Register 0 never creates a hazard.
    clear_inputs(); IsBranch = 1'b1; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
    MemRead_MEM = 1'b1; cycle("rd_zero");

    // Reset while stalled drops the branch.
    clear_inputs(); IsBranch = 1'b1; Rs_ID = 5'd4; MemRead_EX = 1'b1; Rd_EX = 5'd4;
    cycle("rst_pre_stall");
    Reset = 1'b1; cycle("rst_in_stall");
    Reset = 1'b0; clear_inputs(); cycle("rst_after");
    IsBranch = 1'b1; Rs_ID = 5'd4; RegWrite_EX = 1'b1; Rd_EX = 5'd4; BranchTaken = 1'b1;
    cycle("rst_pre_resolve");
    Reset = 1'b1; cycle("rst_in_resolve");
    Reset = 1'b0; clear_inputs(); cycle("rst_after2");

    // Drive both counters to saturation, then one more taken branch.
    IsBranch = 1'b1; BranchTaken = 1'b1;
    for (int i = 0; i < 65536; i++) cycle("sat_fill");
    cycle("sat_hold");
    clear_inputs(); cycle("sat_final");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
